// File: rtl/lif_pkg.sv
// Shared defaults and width helpers for the LIF fire stage and its spike-ID FIFO.
package lif_pkg;

  localparam int VMEM_W_DEF      = 16;
  localparam int NEURON_ID_W_DEF = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int refrac_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/spike_id_fifo.sv
// First-word-fall-through FIFO carrying spike neuron IDs; head reads as 0 while empty.
module spike_id_fifo
  import lif_pkg::*;
#(
  parameter int WIDTH = NEURON_ID_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/p_lif_array.sv
// p_lif_array: N-neuron LIF fire stage with round-robin spike-ID serialiser.
// Per-neuron refractory counters are built only when LIF_REFRACTORY_EN is defined.
module p_lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 16,
  parameter int VMEM_W        = VMEM_W_DEF,
  parameter int NEURON_ID_W   = NEURON_ID_W_DEF,
  parameter int FIFO_DEPTH    = 8,
  parameter int OVF_W         = 8,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          scan_start_en,
  input  logic [N_NEURONS*VMEM_W-1:0]   vmem,
  input  logic [VMEM_W-1:0]             threshold,
  output logic [N_NEURONS-1:0]          reset_vmem,
  output logic [N_NEURONS-1:0]          spike_pulse,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [NEURON_ID_W-1:0]        spike_id,
  output logic [OVF_W-1:0]              overflow_cnt,
  output logic                          busy
);

  localparam int CW = $clog2(N_NEURONS + 1);
  localparam int SW = OVF_W + CW;

  if (N_NEURONS < 2 || N_NEURONS > (1 << NEURON_ID_W) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REFRAC_CYCLES < 1) begin : g_bad_cfg
    $error("p_lif_array: illegal parameter combination");
  end

  logic [N_NEURONS-1:0]   fire, merge, grant_oh;
  logic [N_NEURONS-1:0]   fired_q, fired_d, pending_q, pending_d;
  logic [N_NEURONS-1:0]   reset_vmem_q, spike_pulse_q;
  logic [NEURON_ID_W-1:0] ptr_q, ptr_d, gnt_id;
  logic                   gnt_valid;
  logic [OVF_W-1:0]       ovf_q, ovf_d;
  logic [CW-1:0]          n_merge;
  logic [SW-1:0]          ovf_sum;
  logic                   fifo_full, fifo_empty;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic [VMEM_W-1:0] vmem_cur, vmem_cmp, prev_q;
    logic              armed;

    assign vmem_cur = vmem[i*VMEM_W +: VMEM_W];
    // A scan start clears the accumulator, so the window's last value lives in prev_q.
    assign vmem_cmp = scan_start_en ? prev_q : vmem_cur;
    assign fire[i]  = !fired_q[i] && armed && (vmem_cmp >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= '0;
      else        prev_q <= vmem_cur;
    end

`ifdef LIF_REFRACTORY_EN
    localparam int RW = refrac_w(REFRAC_CYCLES);
    logic [RW-1:0] refrac_q, refrac_d;

    assign refrac_d = fire[i] ? RW'(REFRAC_CYCLES) :
                      (refrac_q != '0) ? refrac_q - RW'(1) : refrac_q;
    assign armed    = (refrac_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) refrac_q <= '0;
      else        refrac_q <= refrac_d;
    end
`else
    assign armed = 1'b1;
`endif
  end

  // Round-robin: ptr_q holds the first index to search, i.e. last grant + 1.
  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      idx = (int'(ptr_q) + k) % N_NEURONS;
      if (!gnt_valid && !fifo_full && pending_q[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = NEURON_ID_W'(idx);
      end
    end
    grant_oh = gnt_valid ? (N_NEURONS'(1) << gnt_id) : '0;
    ptr_d    = ptr_q;
    if (gnt_valid)
      ptr_d = (gnt_id == NEURON_ID_W'(N_NEURONS - 1)) ? '0 : gnt_id + NEURON_ID_W'(1);
  end

  // A fire on an already-pending neuron that is not being granted folds into it.
  assign merge     = fire & pending_q & ~grant_oh;
  assign pending_d = (pending_q & ~grant_oh) | fire;
  assign fired_d   = fire | (scan_start_en ? '0 : fired_q);

  always_comb begin
    n_merge = '0;
    for (int i = 0; i < N_NEURONS; i++) n_merge = n_merge + CW'(merge[i]);
    ovf_sum = SW'(ovf_q) + SW'(n_merge);
    ovf_d   = (ovf_sum > SW'({OVF_W{1'b1}})) ? '1 : ovf_sum[OVF_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fired_q       <= '0;
      pending_q     <= '0;
      reset_vmem_q  <= '0;
      spike_pulse_q <= '0;
      ptr_q         <= '0;
      ovf_q         <= '0;
    end else begin
      fired_q       <= fired_d;
      pending_q     <= pending_d;
      reset_vmem_q  <= fire;
      spike_pulse_q <= fire;
      ptr_q         <= ptr_d;
      ovf_q         <= ovf_d;
    end
  end

  spike_id_fifo #(
    .WIDTH (NEURON_ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt_valid),
    .data_i  (gnt_id),
    .pop_i   (spike_valid && spike_ready),
    .data_o  (spike_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign spike_valid  = !fifo_empty;
  assign reset_vmem   = reset_vmem_q;
  assign spike_pulse  = spike_pulse_q;
  assign overflow_cnt = ovf_q;
  assign busy         = (|pending_q) || !fifo_empty;

endmodule

// File: tb/tb_p_lif_array.sv
// Directed self-checking bench for p_lif_array (default parameters); the refractory
// scenario is compiled in only when LIF_REFRACTORY_EN is defined.
module tb_p_lif_array;

  localparam int N  = 16;
  localparam int VW = 16;

  logic          clk, rst_n, scan_start_en, spike_ready;
  logic [N*VW-1:0] vmem;
  logic [VW-1:0] threshold;
  logic [N-1:0]  reset_vmem, spike_pulse;
  logic          spike_valid, busy;
  logic [3:0]    spike_id;
  logic [7:0]    overflow_cnt;

  int checks = 0;
  int errors = 0;

  p_lif_array dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_start_en (scan_start_en),
    .vmem          (vmem),
    .threshold     (threshold),
    .reset_vmem    (reset_vmem),
    .spike_pulse   (spike_pulse),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .spike_id      (spike_id),
    .overflow_cnt  (overflow_cnt),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input int i, input logic [VW-1:0] v);
    vmem[i*VW +: VW] = v;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; vmem = '0; scan_start_en = 1'b0; spike_ready = 1'b0;
    threshold = '1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vmem = '0; scan_start_en = 1'b0; spike_ready = 1'b0;
    threshold = '1;
    #3;
    checks++; if (spike_pulse !== '0 || reset_vmem !== '0) begin errors++;
      $display("FAIL reset_pulses: got pulse=%h rv=%h expected 0", spike_pulse, reset_vmem); end
    checks++; if (spike_valid !== 1'b0 || spike_id !== '0) begin errors++;
      $display("FAIL reset_fifo: got valid=%b id=%0d expected 0/0", spike_valid, spike_id); end
    checks++; if (overflow_cnt !== '0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_misc: got ovf=%0d busy=%b expected 0/0", overflow_cnt, busy); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fire();
    int extra;
    apply_reset();
    spike_ready = 1'b1;
    threshold = 16'd100; set_v(3, 16'd100);
    tick();
    set_v(3, 16'd0);
    checks++; if (spike_pulse !== 16'h0008 || reset_vmem !== 16'h0008) begin errors++;
      $display("FAIL single_pulse: got pulse=%h rv=%h expected 0008", spike_pulse, reset_vmem); end
    checks++; if (spike_valid !== 1'b0) begin errors++;
      $display("FAIL single_latency: valid=%b one cycle early, expected 0", spike_valid); end
    tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd3 || spike_pulse !== '0) begin errors++;
      $display("FAIL single_id: got valid=%b id=%0d pulse=%h expected 1/3/0000",
               spike_valid, spike_id, spike_pulse); end
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (spike_valid) extra++;
    end
    checks++; if (extra != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL single_once: got %0d extra ids busy=%b expected 0/0", extra, busy); end
  endtask

  task automatic test_scan_edge();
    apply_reset();
    spike_ready = 1'b1;
    threshold = 16'd250; set_v(5, 16'd200);
    tick();
    checks++; if (spike_pulse !== '0) begin errors++;
      $display("FAIL scan_below: got pulse=%h expected 0000", spike_pulse); end
    threshold = 16'd150; set_v(5, 16'd0); scan_start_en = 1'b1;
    tick();
    checks++; if (spike_pulse !== 16'h0020) begin errors++;
      $display("FAIL scan_prev_fire: got pulse=%h expected 0020", spike_pulse); end
    scan_start_en = 1'b0;
    tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd5) begin errors++;
      $display("FAIL scan_id1: got valid=%b id=%0d expected 1/5", spike_valid, spike_id); end
    scan_start_en = 1'b1; set_v(5, 16'd300);
    tick();
    checks++; if (spike_pulse !== '0 || spike_valid !== 1'b0) begin errors++;
      $display("FAIL scan_rearm: got pulse=%h valid=%b expected 0000/0", spike_pulse, spike_valid); end
    scan_start_en = 1'b0; set_v(5, 16'd150);
    tick();
    set_v(5, 16'd0);
    checks++; if (spike_pulse !== 16'h0020) begin errors++;
      $display("FAIL scan_refire: got pulse=%h expected 0020", spike_pulse); end
    tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd5) begin errors++;
      $display("FAIL scan_id2: got valid=%b id=%0d expected 1/5", spike_valid, spike_id); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_ids [3];
    exp_ids = '{4'd0, 4'd7, 4'd15};
    apply_reset();
    spike_ready = 1'b1;
    threshold = 16'd100;
    set_v(0, 16'd500); set_v(7, 16'd500); set_v(15, 16'd500);
    tick();
    vmem = '0;
    checks++; if (spike_pulse !== 16'h8081) begin errors++;
      $display("FAIL simul_pulse: got pulse=%h expected 8081", spike_pulse); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (spike_valid !== 1'b1 || spike_id !== exp_ids[k]) begin errors++;
        $display("FAIL simul_order[%0d]: got valid=%b id=%0d expected 1/%0d",
                 k, spike_valid, spike_id, exp_ids[k]); end
    end
    tick();
    checks++; if (spike_valid !== 1'b0) begin errors++;
      $display("FAIL simul_drain: got valid=%b expected 0", spike_valid); end
    scan_start_en = 1'b1;
    tick();
    scan_start_en = 1'b0;
    set_v(3, 16'd100); set_v(15, 16'd100);
    tick();
    vmem = '0;
    checks++; if (spike_pulse !== 16'h8008) begin errors++;
      $display("FAIL rr_pulse: got pulse=%h expected 8008", spike_pulse); end
    tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd3) begin errors++;
      $display("FAIL rr_wrap_first: got valid=%b id=%0d expected 1/3", spike_valid, spike_id); end
    tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd15) begin errors++;
      $display("FAIL rr_wrap_second: got valid=%b id=%0d expected 1/15", spike_valid, spike_id); end
  endtask

  task automatic test_backpressure();
    int got;
    int bad;
    apply_reset();
    spike_ready = 1'b0;
    threshold = 16'd100;
    for (int i = 0; i < N; i++) set_v(i, 16'd100);
    tick();
    vmem = '0;
    checks++; if (spike_pulse !== 16'hFFFF) begin errors++;
      $display("FAIL bp_pulse: got pulse=%h expected FFFF", spike_pulse); end
    for (int k = 0; k < 10; k++) tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd0 || busy !== 1'b1) begin errors++;
      $display("FAIL bp_hold: got valid=%b id=%0d busy=%b expected 1/0/1",
               spike_valid, spike_id, busy); end
    scan_start_en = 1'b1;
    tick();
    scan_start_en = 1'b0;
    set_v(9, 16'd100);
    tick();
    vmem = '0;
    checks++; if (spike_pulse !== 16'h0200 || overflow_cnt !== 8'd1) begin errors++;
      $display("FAIL bp_merge: got pulse=%h ovf=%0d expected 0200/1", spike_pulse, overflow_cnt); end
    spike_ready = 1'b1;
    got = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (spike_valid) begin
        if (got >= N || spike_id !== 4'(got)) begin
          bad++;
          $display("FAIL bp_order[%0d]: got id=%0d expected %0d", got, spike_id, got);
        end
        got++;
      end
      tick();
    end
    checks++; if (bad != 0) errors++;
    checks++; if (got != N || busy !== 1'b0 || overflow_cnt !== 8'd1) begin errors++;
      $display("FAIL bp_count: got %0d ids busy=%b ovf=%0d expected 16/0/1", got, busy, overflow_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    spike_ready = 1'b0;
    threshold = 16'd100;
    for (int i = 1; i <= 5; i++) set_v(i, 16'd100);
    tick();
    vmem = '0;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (spike_valid !== 1'b1 || spike_id !== 4'd1 || busy !== 1'b1) begin errors++;
      $display("FAIL rmid_queued: got valid=%b id=%0d busy=%b expected 1/1/1",
               spike_valid, spike_id, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (spike_valid !== 1'b0 || spike_id !== '0 || busy !== 1'b0 ||
                  spike_pulse !== '0 || reset_vmem !== '0 || overflow_cnt !== '0) begin errors++;
      $display("FAIL rmid_outputs: got valid=%b id=%0d busy=%b pulse=%h ovf=%0d expected all 0",
               spike_valid, spike_id, busy, spike_pulse, overflow_cnt); end
    tick();
    rst_n = 1'b1;
    spike_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (spike_valid || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL rmid_after: got %0d cycles with valid/busy expected 0", seen); end
  endtask

`ifdef LIF_REFRACTORY_EN
  task automatic test_refractory();
    apply_reset();
    spike_ready = 1'b1;
    threshold = 16'd100; set_v(2, 16'd100);
    tick();
    checks++; if (spike_pulse !== 16'h0004) begin errors++;
      $display("FAIL refr_first: got pulse=%h expected 0004", spike_pulse); end
    scan_start_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      scan_start_en = 1'b0;
      checks++; if (spike_pulse !== '0) begin errors++;
        $display("FAIL refr_hold[%0d]: got pulse=%h expected 0000", k, spike_pulse); end
    end
    tick();
    checks++; if (spike_pulse !== 16'h0004 || overflow_cnt !== '0) begin errors++;
      $display("FAIL refr_refire: got pulse=%h ovf=%0d expected 0004/0", spike_pulse, overflow_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_fire();
    test_scan_edge();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
`ifdef LIF_REFRACTORY_EN
    test_refractory();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
